// File: rtl/stream_mux.sv
// ---------------------------------------------------------------------------
// stream_mux
//
// Registered N-way valid/ready stream multiplexer. It selects one of NUM_IN
// input streams, either by an explicit index (sel) or by round-robin among
// the valid channels. The chosen word lands in a single output register.
//
// Optional feature macro: STREAM_MUX_CNT_EN
//   When defined, this adds a 32-bit output transfer counter on port xfer_count.
//
// Parameters
//   WIDTH   data width per channel (>= 1)
//   NUM_IN  number of input channels (>= 2)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    NUM_IN*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   sel        channel index used in fixed mode
//   rr_mode    0 = fixed select, 1 = round-robin
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data this cycle
//   grant_id   index of the channel that supplied out_data
//   xfer_count (STREAM_MUX_CNT_EN only) number of output transfers, wraps
// ---------------------------------------------------------------------------
module stream_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN*WIDTH-1:0]     in_data,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_ready,
    input  logic [$clog2(NUM_IN)-1:0]   sel,
    input  logic                        rr_mode,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_IN)-1:0]   grant_id
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [31:0]                 xfer_count
`endif
);

    localparam int SEL_W = $clog2(NUM_IN);

    // Round-robin pick: first valid channel scanning ptr+1, ptr+2, ... modulo
    // NUM_IN. The MSB of the result flags that some channel was found.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_IN-1:0] valid,
                                              input logic [SEL_W-1:0]  ptr);
        logic [SEL_W:0] res;
        int             idx;
        res = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (!res[SEL_W] && valid[idx]) begin
                res = {1'b1, SEL_W'(idx)};
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] ch_data [NUM_IN];

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] grant_q,     grant_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic [SEL_W:0]   rr_res;
    logic             chosen_found;
    logic [SEL_W-1:0] chosen_idx;
    logic             can_load;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        rr_res       = rr_pick(in_valid, ptr_q);
        chosen_found = 1'b0;
        chosen_idx   = '0;
        if (rr_mode) begin
            chosen_found = rr_res[SEL_W];
            chosen_idx   = rr_res[SEL_W-1:0];
        end else begin
            // For non-power-of-two NUM_IN, sel can point past the last channel.
            chosen_found = (int'(sel) < NUM_IN);
            chosen_idx   = sel;
        end
    end

    assign can_load = !out_valid_q || out_ready;

    // Ready is one-hot on the chosen channel. In fixed mode it is asserted
    // even if that channel is not valid. It is forced low during reset.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
        assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
        assign in_ready[gi] = rst_n && can_load && chosen_found &&
                              (chosen_idx == SEL_W'(gi));
    end

    assign in_xfer  = |(in_valid & in_ready);
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        // Hold while stalled. Drop when the word drains and nothing new arrives.
        out_valid_d = in_xfer || (out_valid_q && !out_ready);
        if (in_xfer) begin
            out_data_d = ch_data[chosen_idx];
            grant_d    = chosen_idx;
            if (rr_mode) begin
                ptr_d = chosen_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            // Start just behind channel 0 so that channel 0 wins first.
            ptr_q       <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_q;

`ifdef STREAM_MUX_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Wraps naturally from 0xFFFFFFFF to 0.
    assign cnt_d = out_xfer ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`else
    logic unused_out_xfer;
    assign unused_out_xfer = out_xfer;
`endif

endmodule
